// File: rtl/mdl_salign_ctl.sv
// Link alignment controller: resets a word aligner, hunts for a run of ALIGN
// primitives to declare the link up, then forwards non-ALIGN words while the
// link stays active. A link that goes quiet for too long is forced back to RESET.
module mdl_salign_ctl #(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned TIMEOUT      = 200,
  parameter int unsigned RESET_CYCLES = 8,
  parameter logic [31:0] P_ALIGN      = 32'h7b4a4abc
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_keyword,
  input  logic [31:0] i_data,
  output logic        o_align_reset,
  output logic        o_linkup,
  output logic        o_valid,
  output logic        o_keyword,
  output logic [31:0] o_data,
  output logic [15:0] o_resyncs
);

  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned AW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
  localparam logic [AW-1:0] LOCK_LAST = AW'(LOCK_COUNT - 1);
  localparam logic [AW-1:0] LOCK_FULL = AW'(LOCK_COUNT);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [RW-1:0] rst_cnt, rst_cnt_next;
  logic [AW-1:0] align_cnt, align_cnt_next;
  logic [IW-1:0] idle_cnt, idle_cnt_next;
  logic          is_align;
  logic          timeout;
  logic          forward;
  logic          resync;

  assign is_align = i_valid && i_keyword && (i_data == P_ALIGN);

  // The timeout cycle is the one where the idle counter sits at TIMEOUT; a
  // word arriving in that very cycle cancels the timeout.
  assign timeout = (idle_cnt == IDLE_MAX) && !i_valid;

  assign o_align_reset = (state == ST_RESET);
  assign o_linkup      = (state == ST_LOCKED);

  // Next-state logic for the controller and its counters
  always_comb begin
    state_next     = state;
    rst_cnt_next   = rst_cnt;
    align_cnt_next = align_cnt;
    forward        = 1'b0;
    resync         = 1'b0;
    if (i_valid) begin
      idle_cnt_next = '0;
    end else if (idle_cnt == IDLE_MAX) begin
      idle_cnt_next = idle_cnt;
    end else begin
      idle_cnt_next = idle_cnt + 1'b1;
    end

    case (state)
      ST_RESET: begin
        idle_cnt_next  = '0;
        align_cnt_next = '0;
        if (rst_cnt == RST_LAST) begin
          state_next   = ST_HUNT;
          rst_cnt_next = '0;
        end else begin
          rst_cnt_next = rst_cnt + 1'b1;
        end
      end
      ST_HUNT: begin
        if (timeout) begin
          state_next     = ST_RESET;
          rst_cnt_next   = '0;
          align_cnt_next = '0;
          idle_cnt_next  = '0;
        end else if (is_align) begin
          if (align_cnt >= LOCK_LAST) begin
            state_next     = ST_LOCKED;
            align_cnt_next = LOCK_FULL;
          end else begin
            align_cnt_next = align_cnt + 1'b1;
          end
        end else if (i_valid) begin
          align_cnt_next = '0;
        end
      end
      ST_LOCKED: begin
        if (timeout) begin
          state_next     = ST_RESET;
          rst_cnt_next   = '0;
          align_cnt_next = '0;
          idle_cnt_next  = '0;
          resync         = 1'b1;
        end else if (i_valid && !is_align) begin
          forward = 1'b1;
        end
      end
      default: begin
        state_next     = ST_RESET;
        rst_cnt_next   = '0;
        align_cnt_next = '0;
        idle_cnt_next  = '0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_RESET;
      rst_cnt   <= '0;
      align_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_next;
      rst_cnt   <= rst_cnt_next;
      align_cnt <= align_cnt_next;
      idle_cnt  <= idle_cnt_next;
    end
  end

  // Output word register, which holds the last forwarded word, and the resync counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_keyword <= 1'b0;
      o_data    <= '0;
      o_resyncs <= '0;
    end else begin
      o_valid <= forward;
      if (forward) begin
        o_keyword <= i_keyword;
        o_data    <= i_data;
      end
      if (resync && (o_resyncs != 16'hffff)) begin
        o_resyncs <= o_resyncs + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mdl_salign_ctl.sv
// Testbench for mdl_salign_ctl: scenario tasks drive words and check link
// state inline; a monitor pops expected forwarded words from a scoreboard.
module tb_mdl_salign_ctl;

  localparam logic [31:0] P_ALIGN = 32'h7b4a4abc;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        i_keyword;
  logic [31:0] i_data;
  logic        o_align_reset;
  logic        o_linkup;
  logic        o_valid;
  logic        o_keyword;
  logic [31:0] o_data;
  logic [15:0] o_resyncs;

  typedef struct {
    logic        kw;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        head;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          have_last = 1'b0;
  logic        last_kw;
  logic [31:0] last_data;

  mdl_salign_ctl #(
    .LOCK_COUNT(4),
    .TIMEOUT(200),
    .RESET_CYCLES(8),
    .P_ALIGN(P_ALIGN)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_keyword(i_keyword),
    .i_data(i_data),
    .o_align_reset(o_align_reset),
    .o_linkup(o_linkup),
    .o_valid(o_valid),
    .o_keyword(o_keyword),
    .o_data(o_data),
    .o_resyncs(o_resyncs)
  );

  // Free-running clock
  always #5 i_clk = ~i_clk;

  // Edge counter used to time-stamp expected output words
  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: every o_valid pulse must match the head of the scoreboard on its due cycle
  always begin
    @(posedge i_clk);
    #1;
    if (o_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_valid: got o_valid=1 data=%h kw=%b at cycle %0d, required no output",
                 o_data, o_keyword, cyc);
      end else begin
        head = sb.pop_front();
        if (o_data !== head.data || o_keyword !== head.kw || cyc != head.due) begin
          n_fail++;
          $display("[TB] FAIL out_word: got data=%h kw=%b cycle=%0d, required data=%h kw=%b cycle=%0d",
                   o_data, o_keyword, cyc, head.data, head.kw, head.due);
        end
        have_last = 1'b1;
        last_data = head.data;
        last_kw   = head.kw;
      end
    end else begin
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        head = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("[TB] FAIL missing_valid: got o_valid=%b at cycle %0d, required data=%h kw=%b",
                 o_valid, cyc, head.data, head.kw);
      end
      if (have_last) begin
        n_checks++;
        if (o_data !== last_data || o_keyword !== last_kw) begin
          n_fail++;
          $display("[TB] FAIL hold: got data=%h kw=%b, required data=%h kw=%b",
                   o_data, o_keyword, last_data, last_kw);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Drive one word for one cycle; when a forwarded copy is expected, it is scheduled one edge later
  task automatic send(input logic kw, input logic [31:0] data, input bit expect_out);
    exp_t e;
    i_valid   = 1'b1;
    i_keyword = kw;
    i_data    = data;
    if (expect_out) begin
      e.kw   = kw;
      e.data = data;
      e.due  = cyc + 1;
      sb.push_back(e);
    end
    tick();
    i_valid   = 1'b0;
    i_keyword = 1'b0;
    i_data    = '0;
  endtask

  task automatic test_reset();
    i_reset   = 1'b1;
    i_valid   = 1'b0;
    i_keyword = 1'b0;
    i_data    = '0;
    repeat (3) tick();
    n_checks++;
    if (o_align_reset !== 1'b1 || o_linkup !== 1'b0 || o_valid !== 1'b0 ||
        o_keyword !== 1'b0 || o_data !== 32'h0 || o_resyncs !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got ar=%b lu=%b v=%b kw=%b d=%h rs=%h, required ar=1 lu=0 v=0 kw=0 d=0 rs=0",
               o_align_reset, o_linkup, o_valid, o_keyword, o_data, o_resyncs);
    end
    i_reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (o_align_reset !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL reset_pulse: cycle %0d after release got o_align_reset=%b, required 1", k + 1, o_align_reset);
      end
      tick();
    end
    n_checks++;
    if (o_align_reset !== 1'b0 || o_linkup !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_end: got ar=%b lu=%b, required ar=0 lu=0", o_align_reset, o_linkup);
    end
  endtask

  task automatic test_lock();
    for (int k = 0; k < 4; k++) begin
      send(1'b1, P_ALIGN, 1'b0);
      n_checks++;
      if (o_linkup !== (k == 3)) begin
        n_fail++;
        $display("[TB] FAIL lock_progress: after ALIGN %0d got o_linkup=%b, required %b", k + 1, o_linkup, (k == 3));
      end
      if (k < 3) idle(39);
    end
  endtask

  task automatic test_locked_filter();
    send(1'b1, P_ALIGN, 1'b0);
    send(1'b0, 32'hdeadbeef, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 32'hdeadbeef || o_keyword !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL filter_data: got v=%b d=%h kw=%b, required v=1 d=deadbeef kw=0", o_valid, o_data, o_keyword);
    end
    send(1'b1, P_ALIGN, 1'b0);
    n_checks++;
    if (o_valid !== 1'b0 || o_data !== 32'hdeadbeef) begin
      n_fail++;
      $display("[TB] FAIL filter_drop: got v=%b d=%h, required v=0 d=deadbeef", o_valid, o_data);
    end
    send(1'b1, 32'h1f7c7cbc, 1'b1);
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h1f7c7cbc || o_keyword !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL filter_kword: got v=%b d=%h kw=%b, required v=1 d=1f7c7cbc kw=1", o_valid, o_data, o_keyword);
    end
    send(1'b0, P_ALIGN, 1'b1);
    idle(2);
    n_checks++;
    if (o_linkup !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL filter_link: got o_linkup=%b, required 1", o_linkup);
    end
  endtask

  task automatic test_timeout();
    int drop_at;
    send(1'b0, 32'h0badf00d, 1'b1);
    drop_at = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (o_linkup !== 1'b1 && drop_at < 0) drop_at = k;
    end
    n_checks++;
    if (drop_at >= 0) begin
      n_fail++;
      $display("[TB] FAIL timeout_early: link dropped after %0d idle cycles, required hold through 200", drop_at);
    end
    tick();
    n_checks++;
    if (o_linkup !== 1'b0 || o_resyncs !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL timeout_drop: got lu=%b rs=%0d, required lu=0 rs=1", o_linkup, o_resyncs);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (o_align_reset !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL timeout_pulse: cycle %0d got o_align_reset=%b, required 1", k + 1, o_align_reset);
      end
      tick();
    end
    n_checks++;
    if (o_align_reset !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_pulse_end: got o_align_reset=%b, required 0", o_align_reset);
    end
  endtask

  task automatic test_hunt_restart();
    for (int k = 0; k < 3; k++) send(1'b1, P_ALIGN, 1'b0);
    send(1'b0, 32'h12345678, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send(1'b1, P_ALIGN, 1'b0);
      n_checks++;
      if (o_linkup !== (k == 3)) begin
        n_fail++;
        $display("[TB] FAIL hunt_restart: after ALIGN %0d got o_linkup=%b, required %b", k + 1, o_linkup, (k == 3));
      end
    end
    n_checks++;
    if (o_resyncs !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL hunt_resyncs: got %0d, required 1", o_resyncs);
    end
  endtask

  task automatic test_timeout_race();
    send(1'b0, 32'hcafe0001, 1'b1);
    idle(200);
    send(1'b0, 32'hcafe0002, 1'b1);
    idle(5);
    n_checks++;
    if (o_linkup !== 1'b1 || o_align_reset !== 1'b0 || o_resyncs !== 16'd1) begin
      n_fail++;
      $display("[TB] FAIL timeout_race: got lu=%b ar=%b rs=%0d, required lu=1 ar=0 rs=1",
               o_linkup, o_align_reset, o_resyncs);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        kw;
    for (int k = 0; k < 12; k++) begin
      if (k == 5) begin
        send(1'b1, P_ALIGN, 1'b0);
      end else begin
        d  = $urandom;
        kw = 1'($urandom_range(0, 1));
        if (d == P_ALIGN) d = ~d;
        send(kw, d, 1'b1);
      end
    end
    idle(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_drain: got %0d words outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_locked();
    have_last = 1'b0;
    i_reset = 1'b1;
    tick();
    n_checks++;
    if (o_linkup !== 1'b0 || o_align_reset !== 1'b1 || o_resyncs !== 16'd0 ||
        o_valid !== 1'b0 || o_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_locked: got lu=%b ar=%b rs=%0d v=%b d=%h, required lu=0 ar=1 rs=0 v=0 d=0",
               o_linkup, o_align_reset, o_resyncs, o_valid, o_data);
    end
    i_reset = 1'b0;
    idle(2);
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_lock();
    test_locked_filter();
    test_timeout();
    test_hunt_restart();
    test_timeout_race();
    test_back_to_back();
    test_reset_locked();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdl_salign_ctl.md
MDL_SALIGN_CTL -- requirements
Module: mdl_salign_ctl

Interface
REQ-001 SHALL provide parameter LOCK_COUNT, default 4: number of consecutive ALIGN words required to declare link up.
REQ-002 SHALL provide parameter TIMEOUT, default 200: maximum bit-clock cycles allowed between valid input words.
REQ-003 SHALL provide parameter RESET_CYCLES, default 8: duration of the aligner reset pulse.
REQ-004 SHALL provide parameter P_ALIGN, default 32'h7b4a4abc: ALIGN primitive (K28.5 D10.2 D10.2 D27.3, first byte in bits [7:0]).
REQ-005 SHALL have one clock; reset is synchronous and active-high (i_clk, i_reset).
REQ-006 i_clk  input  1  bit clock, shared with the aligner.
REQ-007 i_reset  input  1  synchronous active-high reset.
REQ-008 i_valid  input  1  aligned word strobe from the aligner.
REQ-009 i_keyword  input  1  aligned word carries a control character.
REQ-010 i_data  input  32  aligned word.
REQ-011 o_align_reset  output  1  reset request to the aligner.
REQ-012 o_linkup  output  1  link locked.
REQ-013 o_valid  output  1  filtered word strobe.
REQ-014 o_keyword  output  1  filtered word control flag.
REQ-015 o_data  output  32  filtered word.
REQ-016 o_resyncs  output  16  count of LOCKED-to-RESET transitions, saturating.

Function
REQ-017 SHALL implement states RESET, HUNT and LOCKED.
REQ-018 An ALIGN word SHALL be i_valid && i_keyword && i_data==P_ALIGN.
REQ-019 RESET: o_align_reset=1 for exactly RESET_CYCLES cycles, then go to HUNT with o_align_reset=0; inputs are ignored.
REQ-020 HUNT: an ALIGN word increments align_cnt; any other valid word clears align_cnt to 0.
REQ-021 HUNT: when align_cnt reaches LOCK_COUNT, SHALL enter LOCKED; o_linkup=1 from the cycle after the LOCK_COUNT-th ALIGN word.
REQ-022 LOCKED: ALIGN words SHALL be dropped; every other valid word SHALL appear on o_valid/o_keyword/o_data exactly one cycle later.
REQ-023 o_valid SHALL be 0 in every state other than LOCKED and is a single-cycle pulse per word.
REQ-024 o_keyword/o_data SHALL hold their last value when o_valid=0.
REQ-025 Idle counter: cleared on each i_valid, otherwise incremented in HUNT and LOCKED, saturating.
REQ-026 Idle counter reaching TIMEOUT SHALL force RESET on the next cycle from either HUNT or LOCKED; align_cnt is cleared.
REQ-027 A LOCKED-to-RESET transition SHALL drop o_linkup on the same edge o_align_reset rises and increment o_resyncs, saturating at 16'hffff.
REQ-028 If i_valid coincides with the timeout cycle, the valid word wins: no timeout occurs, and the word is processed normally.
REQ-029 align_cnt SHALL saturate at LOCK_COUNT; it is not used in LOCKED.
REQ-030 Latency: input word to o_valid SHALL be 1 cycle; timeout detection to o_align_reset SHALL be 1 cycle.

Reset
REQ-031 On i_reset: state=RESET, RESET_CYCLES counter restarted, o_align_reset=1, o_linkup=0, o_valid=0, o_keyword=0, o_data=0, o_resyncs=0, and align_cnt and idle counter=0.
REQ-032 i_reset asserted mid-LOCKED SHALL take effect on the next edge, without incrementing o_resyncs.
REQ-033 Parameters SHALL satisfy LOCK_COUNT>=1, TIMEOUT>=2 and RESET_CYCLES>=1.

Verification
REQ-034 Reset release, then 4 ALIGN words every 40 cycles -> o_align_reset high for cycles 1-8; o_linkup=1 one cycle after the 4th ALIGN word; o_valid never asserted.
REQ-035 In HUNT, 3 ALIGN words, then data 32'h12345678 (keyword=0), then 4 ALIGN words -> linkup only after the final 4th ALIGN word; no o_valid.
REQ-036 LOCKED, inputs ALIGN, 32'hdeadbeef, ALIGN, K-word 32'h1f7c7cbc -> exactly two o_valid pulses, carrying deadbeef/kw=0 and 1f7c7cbc/kw=1, each 1 cycle after its input.
REQ-037 LOCKED, no i_valid for 200 cycles -> o_linkup=0, o_align_reset=1 for 8 cycles, o_resyncs=1; relock with 4 ALIGN words restores linkup.
REQ-038 i_valid arrives exactly on the timeout cycle -> no resync, o_resyncs unchanged.
REQ-039 i_reset asserted while LOCKED -> next cycle: o_linkup=0, o_align_reset=1, o_resyncs=0.
